serial_frame_receiver: RTL

//  Receiver for the framed serial result stream (start_c frame strobe + c data bit) produced by
//  the serial arithmetic core. Collects the bits of one frame LSB-first into a parallel word and

---
 rtl/serial_frame_receiver.sv | 105 ++++++++++
 1 files changed

// File: rtl/serial_frame_receiver.sv
// Deserialises LSB-first frames (start_c strobe + c bit) into a parallel word held
// in a one-entry valid/ready output register, with length, overflow and drop status.
module serial_frame_receiver #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_c,
   input  logic             c,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] out_len,
   output logic             out_ovf,
   output logic             busy,
   output logic             drop
);

   typedef enum logic {IDLE, RECV} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   shift_q, shift_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_q, ovf_d;
   logic               out_valid_d, out_ovf_d, drop_d;
   logic [WIDTH-1:0]   out_data_d;
   logic [CNT_W-1:0]   out_len_d;

   // NOTE: every output comes straight from a flop, so no input reaches an output combinationally.
   assign busy = (state_q == RECV);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_len   <= '0;
         out_ovf   <= 1'b0;
         drop      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge values.
         state_q   <= state_d;
         shift_q   <= shift_d;
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
         out_valid <= out_valid_d;
         out_data  <= out_data_d;
         out_len   <= out_len_d;
         out_ovf   <= out_ovf_d;
         drop      <= drop_d;
      end
   end

   always_comb begin
      // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
      state_d     = state_q;
      shift_d     = shift_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid & ~out_ready;
      out_data_d  = out_data;
      out_len_d   = out_len;
      out_ovf_d   = out_ovf;
      drop_d      = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start_c) begin
               // Clearing the buffer here keeps unfilled MSBs at zero.
               shift_d = WIDTH'(c);
               cnt_d   = CNT_W'(1);
               ovf_d   = 1'b0;
               state_d = RECV;
            end
         end
         RECV: begin
            if (start_c) begin
               if (cnt_q < CNT_W'(WIDTH)) begin
                  shift_d = shift_q | (WIDTH'(c) << cnt_q);
                  cnt_d   = cnt_q + CNT_W'(1);
               end else begin
                  ovf_d = 1'b1;
               end
            end else begin
               state_d = IDLE;
               // A full register that is accepted on this edge may be refilled on it.
               if (!out_valid || out_ready) begin
                  out_valid_d = 1'b1;
                  out_data_d  = shift_q;
                  out_len_d   = cnt_q;
                  out_ovf_d   = ovf_q;
               end else begin
                  drop_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
